// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parametrised serial pattern detector and the
// statistics blocks around it.
//   SEQ_DET_PAT_W_DEFAULT   : default pattern length (bits)
//   SEQ_DET_CNT_W_DEFAULT   : default match counter width
//   SEQ_DET_PAT_RST_DEFAULT : pattern loaded at reset (MSB = oldest bit)
//   seq_det_ones(width)     : all-ones value of the given width (1..32),
//                             returned right-aligned in 32 bits
// ---------------------------------------------------------------------------
package seq_det_pkg;

  localparam int unsigned SEQ_DET_PAT_W_DEFAULT = 12;
  localparam int unsigned SEQ_DET_CNT_W_DEFAULT = 9;
  localparam logic [11:0] SEQ_DET_PAT_RST_DEFAULT = 12'b110001110010;

  function automatic logic [31:0] seq_det_ones(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/seq_det_param_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating event counter with a sticky saturation flag.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   inc   : count one event this cycle
//   clr   : clear count and flag; has priority over inc
//   count : current count, holds at all-ones
//   sat   : sticky, set when an event arrives while count is all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_reg;
  logic             sat_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else if (inc) begin
      if (count_reg == {CNT_W{1'b1}}) begin
        sat_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign count = count_reg;
  assign sat   = sat_reg;

endmodule

// File: rtl/seq_det_param.sv
// ---------------------------------------------------------------------------
// seq_det_param
// Parametrised serial pattern detector. Accepted bits shift into a history
// register; once PAT_W bits have been accepted (since reset, pattern load or
// the last non-overlapping match) the history is compared against the
// runtime-loadable pattern. A match gives a one-cycle pulse one clock after
// the completing bit and bumps a saturating match counter.
//
// Optional build macro: SEQ_DET_MASK_EN adds pat_mask_in; the mask is loaded
// with pat_load and its 0 bits are don't-care. Without it the compare is exact.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   bit_in       : serial data bit
//   bit_valid    : bit_in accepted this cycle
//   overlap      : 1 = overlapping matches, 0 = non-overlapping
//   pat_load     : load pat_in (and pat_mask_in) as the new pattern
//   pat_in       : new pattern, MSB is the oldest bit
//   pat_mask_in  : (SEQ_DET_MASK_EN only) compare mask, 0 = don't care
//   max_tick_reg : LFSR full-cycle tick, clears match statistics
//   seq_detected : one-cycle match pulse
//   match_count  : matches since last clear (saturating)
//   count_sat    : sticky saturation flag
// ---------------------------------------------------------------------------
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = SEQ_DET_PAT_W_DEFAULT,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(SEQ_DET_PAT_RST_DEFAULT),
  parameter int               CNT_W   = SEQ_DET_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
`endif
  input  logic             max_tick_reg,
  output logic             seq_detected,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [31:0]      ONES_32   = seq_det_ones(PAT_W);
  localparam logic [PAT_W-1:0] MASK_ALL  = ONES_32[PAT_W-1:0];

  logic [PAT_W-1:0]  pat_reg;
  logic [PAT_W-1:0]  hist_reg;
  logic [FILL_W-1:0] fill_reg;
  logic              seq_detected_reg;
  logic [PAT_W-1:0]  mask_cur;

  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill_next;
  logic              accept;
  logic              match_next;

`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg <= MASK_ALL;
    end else if (pat_load) begin
      mask_reg <= pat_mask_in;
    end
  end

  assign mask_cur = mask_reg;
`else
  assign mask_cur = MASK_ALL;
`endif

  // A bit arriving together with a pattern load is dropped: the load wins.
  assign accept    = bit_valid && !pat_load;
  assign hist_next = {hist_reg[PAT_W-2:0], bit_in};
  assign fill_next = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + 1'b1;

  // fill_next reaching PAT_W means the window holds only bits accepted since
  // the last restart point, so a partially filled window can never match.
  assign match_next = accept && (fill_next == FILL_FULL) &&
                      (((hist_next ^ pat_reg) & mask_cur) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg          <= PAT_RST;
      hist_reg         <= '0;
      fill_reg         <= '0;
      seq_detected_reg <= 1'b0;
    end else begin
      seq_detected_reg <= match_next;
      if (pat_load) begin
        pat_reg  <= pat_in;
        fill_reg <= '0;
      end else if (bit_valid) begin
        hist_reg <= hist_next;
        // Non-overlapping mode restarts the window after a match; the
        // history keeps shifting but needs PAT_W fresh bits to qualify.
        fill_reg <= (match_next && !overlap) ? '0 : fill_next;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match_next),
    .clr   (max_tick_reg),
    .count (match_count),
    .sat   (count_sat)
  );

  assign seq_detected = seq_detected_reg;

endmodule

// File: tb/tb_seq_det_param.sv
// ---------------------------------------------------------------------------
// tb_seq_det_param
// Two detector instances: "a" with the default 12-bit pattern / 9-bit count,
// "b" with a 4-bit pattern (1010) and a 2-bit count for saturation tests.
// A reference model keeps the log of bits accepted since the last restart
// point and checks the newest PAT_W of them against the pattern.
// ---------------------------------------------------------------------------
module tb_seq_det_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a
  logic        a_rst = 1'b1, a_bit = 1'b0, a_valid = 1'b0, a_ovl = 1'b1;
  logic        a_load = 1'b0, a_tick = 1'b0;
  logic [11:0] a_pat = '0;
  logic        a_det;
  logic [8:0]  a_cnt;
  logic        a_sat;
  // instance b
  logic        b_rst = 1'b1, b_bit = 1'b0, b_valid = 1'b0, b_ovl = 1'b1;
  logic        b_load = 1'b0, b_tick = 1'b0;
  logic [3:0]  b_pat = '0;
  logic        b_det;
  logic [1:0]  b_cnt;
  logic        b_sat;
`ifdef SEQ_DET_MASK_EN
  logic [11:0] a_mask = '1;
  logic [3:0]  b_mask = '1;
`endif

  seq_det_param dut_a (
    .clk          (clk),
    .rst          (a_rst),
    .bit_in       (a_bit),
    .bit_valid    (a_valid),
    .overlap      (a_ovl),
    .pat_load     (a_load),
    .pat_in       (a_pat),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in  (a_mask),
`endif
    .max_tick_reg (a_tick),
    .seq_detected (a_det),
    .match_count  (a_cnt),
    .count_sat    (a_sat)
  );

  seq_det_param #(
    .PAT_W   (4),
    .PAT_RST (4'b1010),
    .CNT_W   (2)
  ) dut_b (
    .clk          (clk),
    .rst          (b_rst),
    .bit_in       (b_bit),
    .bit_valid    (b_valid),
    .overlap      (b_ovl),
    .pat_load     (b_load),
    .pat_in       (b_pat),
`ifdef SEQ_DET_MASK_EN
    .pat_mask_in  (b_mask),
`endif
    .max_tick_reg (b_tick),
    .seq_detected (b_det),
    .match_count  (b_cnt),
    .count_sat    (b_sat)
  );

  // ---------------- reference model ----------------
  bit          mq [2][$];
  logic [31:0] m_pat [2];
  int          m_w [2]   = '{12, 4};
  int          m_max [2] = '{511, 3};
  bit          e_det [2];
  int          e_cnt [2];
  bit          e_sat [2];

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [11:0] PAT_A = 12'b110001110010;
  localparam logic [11:0] PAT_N = 12'b111100001111;

  function automatic void model_step(int i, bit r, bit v, bit b, bit ov,
                                     bit ld, logic [31:0] pin, bit tk);
    logic [31:0] win;
    bit          hit;
    hit = 1'b0;
    if (r) begin
      mq[i].delete();
      m_pat[i] = (i == 0) ? 32'h0000_0C72 : 32'h0000_000A;
      e_det[i] = 1'b0;
      e_cnt[i] = 0;
      e_sat[i] = 1'b0;
      return;
    end
    if (ld) begin
      m_pat[i] = pin;
      mq[i].delete();
    end else if (v) begin
      mq[i].push_back(b);
      if (mq[i].size() > m_w[i]) void'(mq[i].pop_front());
      if (mq[i].size() == m_w[i]) begin
        win = '0;
        for (int k = 0; k < mq[i].size(); k++) win = {win[30:0], mq[i][k]};
        hit = (win == m_pat[i]);
        if (hit && !ov) mq[i].delete();
      end
    end
    e_det[i] = hit;
    if (tk) begin
      e_cnt[i] = 0;
      e_sat[i] = 1'b0;
    end else if (hit) begin
      if (e_cnt[i] == m_max[i]) e_sat[i] = 1'b1;
      else e_cnt[i] = e_cnt[i] + 1;
    end
  endfunction

  // Advance one clock; inputs are driven 1 time unit after each edge.
  task automatic cyc();
    @(posedge clk);
    model_step(0, a_rst, a_valid, a_bit, a_ovl, a_load, {20'd0, a_pat}, a_tick);
    model_step(1, b_rst, b_valid, b_bit, b_ovl, b_load, {28'd0, b_pat}, b_tick);
    #1;
    a_load = 1'b0; a_tick = 1'b0;
    b_load = 1'b0; b_tick = 1'b0;
  endtask

  task automatic a_reset();
    a_rst = 1'b1; a_valid = 1'b0; cyc(); a_rst = 1'b0;
  endtask

  task automatic b_reset();
    b_rst = 1'b1; b_valid = 1'b0; cyc(); b_rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_valid = 1'b1; a_bit = 1'b1; b_valid = 1'b1; b_bit = 1'b1;
    cyc(); cyc();
    n_tests++;
    if (a_det !== 1'b0 || a_cnt !== 9'd0 || a_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a det/cnt/sat=%b/%0d/%b want 0/0/0", a_det, a_cnt, a_sat);
    end
    n_tests++;
    if (b_det !== 1'b0 || b_cnt !== 2'd0 || b_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b det/cnt/sat=%b/%0d/%b want 0/0/0", b_det, b_cnt, b_sat);
    end
    a_rst = 1'b0; b_rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_fixed_pattern();
    logic [11:0] p;
    p = PAT_A;
    a_ovl = 1'b1;
    for (int k = 11; k >= 0; k--) begin
      a_valid = 1'b1; a_bit = p[k];
      cyc();
      n_tests++;
      if (a_det !== (k == 0)) begin
        n_fail++;
        $display("FAIL fixed_det bit %0d det=%b want %b", 12 - k, a_det, (k == 0));
      end
    end
    a_valid = 1'b0;
    cyc();
    n_tests++;
    if (a_det !== 1'b0 || a_cnt !== 9'd1) begin
      n_fail++;
      $display("FAIL fixed_after det/cnt=%b/%0d want 0/1", a_det, a_cnt);
    end
    $display("[TB] test_fixed_pattern done, count=%0d", a_cnt);
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    bit         want;
    s = 7'b1010101;
    for (int ov = 1; ov >= 0; ov--) begin
      b_reset();
      b_ovl = ov[0];
      for (int n = 1; n <= 7; n++) begin
        b_valid = 1'b1; b_bit = s[7 - n];
        cyc();
        want = (n == 4) || (ov == 1 && n == 6);
        n_tests++;
        if (b_det !== want || b_det !== e_det[1]) begin
          n_fail++;
          $display("FAIL overlap%0d_det bit %0d det=%b want %b", ov, n, b_det, want);
        end
      end
      b_valid = 1'b0;
      cyc();
      n_tests++;
      if (b_cnt !== ((ov == 1) ? 2'd2 : 2'd1)) begin
        n_fail++;
        $display("FAIL overlap%0d_cnt cnt=%0d want %0d", ov, b_cnt, (ov == 1) ? 2 : 1);
      end
      $display("[TB] test_overlap overlap=%0d count=%0d", ov, b_cnt);
    end
    b_ovl = 1'b1;
  endtask

  task automatic test_gaps();
    logic [11:0] p;
    int          gap;
    p = PAT_A;
    a_reset();
    a_ovl = 1'b1;
    for (int k = 11; k >= 0; k--) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        a_valid = 1'b0; a_bit = 1'($urandom);
        cyc();
        n_tests++;
        if (a_det !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_det before bit %0d det=%b want 0", 12 - k, a_det);
        end
      end
      a_valid = 1'b1; a_bit = p[k];
      cyc();
      n_tests++;
      if (a_det !== (k == 0) || a_cnt !== 9'(e_cnt[0])) begin
        n_fail++;
        $display("FAIL gap_bit bit %0d det/cnt=%b/%0d want %b/%0d", 12 - k, a_det, a_cnt, (k == 0), e_cnt[0]);
      end
    end
    a_valid = 1'b0;
    cyc();
    n_tests++;
    if (a_det !== 1'b0 || a_cnt !== 9'd1) begin
      n_fail++;
      $display("FAIL gap_after det/cnt=%b/%0d want 0/1", a_det, a_cnt);
    end
    $display("[TB] test_gaps done, count=%0d", a_cnt);
  endtask

  task automatic test_load();
    logic [11:0] p;
    logic [11:0] q;
    p = PAT_A;
    q = PAT_N;
    a_reset();
    a_ovl = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; a_bit = 1'($urandom); cyc();
    end
    a_load = 1'b1; a_pat = q; a_valid = 1'b1; a_bit = 1'b1;
    cyc();
    n_tests++;
    if (a_det !== 1'b0) begin
      n_fail++;
      $display("FAIL load_same_cycle det=%b want 0", a_det);
    end
    for (int k = 11; k >= 0; k--) begin
      a_valid = 1'b1; a_bit = p[k];
      cyc();
      n_tests++;
      if (a_det !== 1'b0) begin
        n_fail++;
        $display("FAIL load_old_pat bit %0d det=%b want 0", 12 - k, a_det);
      end
    end
    for (int k = 11; k >= 0; k--) begin
      a_valid = 1'b1; a_bit = q[k];
      cyc();
      n_tests++;
      if (a_det !== e_det[0] || (k == 0 && a_det !== 1'b1)) begin
        n_fail++;
        $display("FAIL load_new_pat bit %0d det=%b want %b", 12 - k, a_det, e_det[0]);
      end
    end
    a_valid = 1'b0;
    cyc();
    n_tests++;
    if (a_cnt !== 9'(e_cnt[0]) || a_sat !== e_sat[0]) begin
      n_fail++;
      $display("FAIL load_cnt cnt/sat=%0d/%b want %0d/%b", a_cnt, a_sat, e_cnt[0], e_sat[0]);
    end
    $display("[TB] test_load done, count=%0d", a_cnt);
  endtask

  task automatic test_saturate();
    int exp_c [13];
    bit exp_s [13];
    b_reset();
    b_ovl = 1'b1;
    exp_c[4] = 1;  exp_s[4] = 0;
    exp_c[6] = 2;  exp_s[6] = 0;
    exp_c[8] = 3;  exp_s[8] = 0;
    exp_c[10] = 3; exp_s[10] = 1;
    exp_c[12] = 0; exp_s[12] = 0;
    for (int n = 1; n <= 12; n++) begin
      b_valid = 1'b1; b_bit = (n % 2 == 1);
      if (n == 12) b_tick = 1'b1;
      cyc();
      if (n >= 4 && n % 2 == 0) begin
        n_tests++;
        if (b_det !== 1'b1 || b_cnt !== 2'(exp_c[n]) || b_sat !== exp_s[n]) begin
          n_fail++;
          $display("FAIL sat_match bit %0d det/cnt/sat=%b/%0d/%b want 1/%0d/%b", n, b_det, b_cnt, b_sat, exp_c[n], exp_s[n]);
        end
      end
    end
    b_valid = 1'b0;
    $display("[TB] test_saturate done, count=%0d sat=%b", b_cnt, b_sat);
  endtask

  task automatic test_rst_mid();
    logic [11:0] p;
    p = PAT_A;
    a_reset();
    a_ovl = 1'b0;
    for (int k = 11; k >= 0; k--) begin
      a_valid = 1'b1; a_bit = p[k]; cyc();
    end
    for (int k = 11; k >= 1; k--) begin
      a_valid = 1'b1; a_bit = p[k]; cyc();
    end
    a_rst = 1'b1; a_valid = 1'b1; a_bit = p[0];
    cyc();
    n_tests++;
    if (a_det !== 1'b0 || a_cnt !== 9'd0 || a_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid det/cnt/sat=%b/%0d/%b want 0/0/0", a_det, a_cnt, a_sat);
    end
    a_rst = 1'b0; a_valid = 1'b1; a_bit = p[0];
    cyc();
    n_tests++;
    if (a_det !== 1'b0 || a_cnt !== 9'd0) begin
      n_fail++;
      $display("FAIL rst_mid_12th det/cnt=%b/%0d want 0/0", a_det, a_cnt);
    end
    a_valid = 1'b0; a_ovl = 1'b1;
    $display("[TB] test_rst_mid done");
  endtask

  task automatic test_random();
    int a_k = 0;
    int bad = 0;
    for (int c = 0; c < 1500; c++) begin
      a_rst = ($urandom_range(0, 299) == 0);
      b_rst = ($urandom_range(0, 299) == 0);
      a_tick = ($urandom_range(0, 149) == 0);
      b_tick = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) a_ovl = ~a_ovl;
      if ($urandom_range(0, 19) == 0) b_ovl = ~b_ovl;
      a_load = ($urandom_range(0, 99) == 0);
      b_load = ($urandom_range(0, 99) == 0);
      a_pat = 12'($urandom);
      b_pat = 4'($urandom);
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      // feed instance a mostly its own pattern so long matches occur
      a_bit = m_pat[0][11 - (a_k % 12)] ^ ($urandom_range(0, 15) == 0);
      b_bit = 1'($urandom);
      if (a_load || a_rst) a_k = 0;
      else if (a_valid) a_k++;
      cyc();
      n_tests++;
      if (a_det !== e_det[0] || a_cnt !== 9'(e_cnt[0]) || a_sat !== e_sat[0]) begin
        n_fail++; bad++;
        $display("FAIL rand_a cyc %0d det/cnt/sat=%b/%0d/%b want %b/%0d/%b", c, a_det, a_cnt, a_sat, e_det[0], e_cnt[0], e_sat[0]);
      end
      n_tests++;
      if (b_det !== e_det[1] || b_cnt !== 2'(e_cnt[1]) || b_sat !== e_sat[1]) begin
        n_fail++; bad++;
        $display("FAIL rand_b cyc %0d det/cnt/sat=%b/%0d/%b want %b/%0d/%b", c, b_det, b_cnt, b_sat, e_det[1], e_cnt[1], e_sat[1]);
      end
    end
    a_rst = 1'b0; b_rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    $display("[TB] test_random done, %0d bad cycles", bad);
  endtask

  initial begin
    #1;
    test_reset();
    test_fixed_pattern();
    test_overlap();
    test_gaps();
    test_load();
    test_saturate();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
